imem_loader: RTL

- Writer side of the instruction memory that the pipeline's fetch stage reads.
- Accepts a framed, little-endian byte stream over a valid/ready handshake and assembles it into 32-bit words.
- Writes each word into instruction memory at consecutive word addresses.
- Holds the CPU pipeline (cpu_hold) for the whole load, so fetch never sees a half-written program.

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_assembler.sv | 35 +++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and the instruction memory.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

    // Geometry shared with instruction_memory.
    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned IMEM_DEPTH  = 256;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StWrite,
        StDone,
        StChk
    } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; word_ready pulses on the cycle the last lane is shifted in,
// with word already including that byte.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_ready
);

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (shift_en) begin
            lane_q                 <= lane_q + LANE_W'(1);
            word_q[8*lane_q +: 8]  <= byte_data;
        end
    end

    // Merge the byte on the bus so the owner can capture a full word on the same edge.
    always_comb begin
        word                 = word_q;
        word[8*lane_q +: 8]  = byte_data;
        word_ready           = shift_en && (lane_q == LANE_W'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (count header + words) into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte and csum_err port: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned DEPTH     = IMEM_DEPTH,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic              overflow,
    output logic              csum_err
`else
    output logic              overflow
`endif
);

    state_t            state_q;
    logic [WORD_W-1:0] count_q;
    logic [WORD_W-1:0] wcnt_q;
    logic              xfer;
    logic              asm_clear;
    logic              asm_shift;
    logic [WORD_W-1:0] asm_word;
    logic              asm_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign asm_clear = start && (state_q == StIdle || state_q == StDone);
    assign asm_shift = xfer && (state_q == StHdr || state_q == StData);

    byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .shift_en   (asm_shift),
        .byte_data  (byte_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            wcnt_q     <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= ADDR_W'(BASE_ADDR);
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            csum_err   <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer) begin
                csum_q <= csum_q ^ byte_data;
            end
`endif
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StHdr;
                        wcnt_q     <= '0;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= '0;
                        csum_err   <= 1'b0;
`endif
                    end
                end
                StHdr: begin
                    if (asm_ready) begin
                        count_q  <= asm_word;
                        overflow <= (asm_word > DEPTH);
                        if (asm_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_q    <= StChk;
`else
                            state_q    <= StDone;
                            byte_ready <= 1'b0;
                            cpu_hold   <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
`endif
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (asm_ready) begin
                        state_q    <= StWrite;
                        byte_ready <= 1'b0;
                        // Words past DEPTH are drained from the stream but never written.
                        imem_we    <= (wcnt_q < DEPTH);
                        imem_addr  <= ADDR_W'(BASE_ADDR + wcnt_q);
                        imem_wdata <= asm_word;
                    end
                end
                StWrite: begin
                    wcnt_q <= wcnt_q + 32'd1;
                    if (wcnt_q + 32'd1 == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_q    <= StChk;
                        byte_ready <= 1'b1;
`else
                        state_q    <= StDone;
                        cpu_hold   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        state_q    <= StData;
                        byte_ready <= 1'b1;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (xfer) begin
                        csum_err   <= (byte_data != csum_q);
                        state_q    <= StDone;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q    <= StIdle;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
